network_bf_in_xbar: RTL and testbench
=====================================

Name: network_bf_in_xbar

Overview:
- Parametrised bank-to-butterfly input crossbar for the NTT/INTT datapath. Routes LANES memory-bank read words to LANES butterfly operand slots (slot order u0, v0, u1, v1, ...).
- Delays the route selects and a valid tag through a configurable pipeline so they line up with bank read latency. An optional output register is provided.
- Detects destination collisions, flags them in a sticky error bit and counts them. A global stall (en) freezes the pipeline.

Parameters:
- DATA_W, 23, coefficient width in bits.
- LANES, 4, number of banks and of operand slots; power of two, 2..8.
- SEL_W, $clog2(LANES), width of one select field (derived; do not override).
- SEL_DLY, 1, cycles of select/valid delay matching bank read latency; 1..4.
- OUT_REG, 1, 1 = registered outputs (+1 cycle latency), 0 = combinational outputs from delayed select and q.
- CNT_W, 8, width of the collision counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- en  in  1  pipeline advance; 0 = stall, all state holds.
- in_valid  in  1  sel_a is valid this cycle (bank read issued).
- sel_a  in  LANES*SEL_W  field i = destination slot for bank i.
- q  in  LANES*DATA_W  bank read data; word i = bank i; valid SEL_DLY cycles after the matching sel_a.
- err_clr  in  1  clears the sticky collision flag.
- out_data  out  LANES*DATA_W  word j = operand slot j.
- out_valid  out  1  out_data is valid.
- collision  out  1  sticky: two banks targeted the same slot on a valid beat.
- coll_cnt  out  CNT_W  saturating count of collided valid beats.

Behaviour:
- Reset: when rst=0 at a clock edge, all select/valid pipeline stages, out_data, out_valid, collision and coll_cnt go to 0. Reset takes priority over en and err_clr. Asserting reset mid-operation drops all in-flight beats; no partial output appears after release.
- Select pipeline:
  - SEL_DLY stages of {in_valid, sel_a}.
  - Advances only when en=1. When en=0, every stage, the output register and the counters hold.
  - The stage-SEL_DLY select (sel_d) and valid (vld_d) pair with the q present in that same cycle.
- Routing (combinational on sel_d, q):
  - Every slot defaults to 0.
  - Bank i writes slot sel_d[i].
  - If several banks target one slot, the highest-index bank wins.
  - Slots targeted by no bank output 0.
  - Routing is applied regardless of vld_d; out_valid qualifies the data.
- Output stage:
  - OUT_REG=1: out_data and out_valid are registered when en=1. Total latency from in_valid to out_valid = SEL_DLY+1; data is q captured SEL_DLY cycles after sel_a.
  - OUT_REG=0: out_data and out_valid = routed value and vld_d directly. Latency = SEL_DLY.
- Collision detection:
  - Evaluated on sel_d when vld_d=1 and en=1. A collision exists when any two select fields are equal, i.e. the selects are not a permutation.
  - On a collision, the sticky collision bit goes to 1 on the next edge.
  - On a collision, coll_cnt increments by 1 on the next edge, saturating at 2^CNT_W-1 with no wrap.
  - Invalid beats (vld_d=0) never flag.
- err_clr:
  - Clears collision on the next edge.
  - If a new collision is detected in the same cycle, set wins and collision stays 1.
  - err_clr does not clear coll_cnt; only reset does.
  - err_clr acts even when en=0.
- Back-to-back operation: one new beat per cycle is accepted with no bubbles. Stalls insert no bubbles and lose no beats.
- collision and coll_cnt register timing is independent of OUT_REG.

Test Plan (LANES=4, DATA_W=23, SEL_DLY=1, OUT_REG=1 unless noted):
- Permutation route: in_valid=1, sel_a fields (bank0..3)={2,0,3,1}; next cycle q={0x11,0x22,0x33,0x44} -> 2 cycles after in_valid: out_valid=1, out_data slots (u0,v0,u1,v1)={0x22,0x44,0x11,0x33}, collision=0, coll_cnt=0.
- Collision priority: sel_a={1,1,0,1}, q={5,6,7,8} -> out_data={7,8,0,0}, out_valid=1, collision=1, coll_cnt=1. Then err_clr=1 for one cycle with no further collisions -> collision=0, coll_cnt stays 1.
- Stall: beats A, B, C on consecutive cycles; en=0 for 3 cycles after B is issued, with q held stable by the bench -> out_valid sequence A, (hold), B, C. No beat is lost or duplicated, and out_data holds during the stall.
- Invalid beat: in_valid=0 with sel_a={0,0,0,0} -> collision stays 0, coll_cnt unchanged, out_valid=0.
- Saturation and clear race: CNT_W=2, 5 consecutive collided beats -> coll_cnt=3 (saturated). Assert err_clr on the same cycle as a collided vld_d -> collision remains 1.
- Reset mid-flight and variants: assert rst=0 one cycle after in_valid -> out_valid never rises; all outputs are 0 the cycle after reset. Repeat the permutation case with SEL_DLY=3, OUT_REG=0 -> out_valid 3 cycles after in_valid, same slot mapping.

Source files
------------

// File: rtl/network_bf_in_xbar.sv
// Bank-to-butterfly input crossbar: delays route selects to line up with bank
// read latency, routes bank words to operand slots, and flags slot collisions.
module network_bf_in_xbar #(
  parameter int unsigned DATA_W  = 23,
  parameter int unsigned LANES   = 4,
  parameter int unsigned SEL_W   = $clog2(LANES),
  parameter int unsigned SEL_DLY = 1,
  parameter int unsigned OUT_REG = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [LANES*SEL_W-1:0]  sel_a,
  input  logic [LANES*DATA_W-1:0] q,
  input  logic                    err_clr,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    collision,
  output logic [CNT_W-1:0]        coll_cnt
);

  // Select/valid delay line; index SEL_DLY-1 is the stage paired with q.
  logic [LANES*SEL_W-1:0]  sel_pipe_q [SEL_DLY];
  logic                    vld_pipe_q [SEL_DLY];
  logic [LANES*SEL_W-1:0]  sel_d;
  logic                    vld_d;
  logic [SEL_W-1:0]        sel_f [LANES];
  logic [DATA_W-1:0]       slot_w [LANES];
  logic [LANES*DATA_W-1:0] routed;
  logic                    coll_hit;
  logic                    coll_q;
  logic [CNT_W-1:0]        coll_cnt_q;

  assign sel_d = sel_pipe_q[SEL_DLY-1];
  assign vld_d = vld_pipe_q[SEL_DLY-1];

  // Shift selects and valid tag forward when the pipeline advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SEL_DLY; k++) begin
        sel_pipe_q[k] <= '0;
        vld_pipe_q[k] <= 1'b0;
      end
    end else if (en) begin
      sel_pipe_q[0] <= sel_a;
      vld_pipe_q[0] <= in_valid;
      for (int k = 1; k < SEL_DLY; k++) begin
        sel_pipe_q[k] <= sel_pipe_q[k-1];
        vld_pipe_q[k] <= vld_pipe_q[k-1];
      end
    end
  end

  // Route banks to slots; later (higher-index) banks override earlier ones.
  always_comb begin
    routed = '0;
    for (int i = 0; i < LANES; i++) begin
      sel_f[i]  = sel_d[i*SEL_W +: SEL_W];
      slot_w[i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      slot_w[sel_f[i]] = q[i*DATA_W +: DATA_W];
    end
    for (int j = 0; j < LANES; j++) begin
      routed[j*DATA_W +: DATA_W] = slot_w[j];
    end
  end

  // Any equal pair of select fields means the selects are not a permutation.
  always_comb begin
    coll_hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (sel_f[i] == sel_f[j]) coll_hit = 1'b1;
      end
    end
  end

  // Sticky flag (set beats clear) and saturating collision counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      if (en && vld_d && coll_hit) begin
        coll_q <= 1'b1;
      end else if (err_clr) begin
        coll_q <= 1'b0;
      end
      if (en && vld_d && coll_hit && (coll_cnt_q != {CNT_W{1'b1}})) begin
        coll_cnt_q <= coll_cnt_q + 1'b1;
      end
    end
  end

  assign collision = coll_q;
  assign coll_cnt  = coll_cnt_q;

  if (OUT_REG != 0) begin : g_out_reg
    // Registered output stage, held while stalled.
    always_ff @(posedge clk) begin
      if (!rst) begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end else if (en) begin
        out_data  <= routed;
        out_valid <= vld_d;
      end
    end
  end else begin : g_out_comb
    assign out_data  = routed;
    assign out_valid = vld_d;
  end

endmodule

// File: tb/tb_network_bf_in_xbar.sv
// Directed bench: default config, a CNT_W=2 instance and a SEL_DLY=3/OUT_REG=0
// instance share one stimulus stream; each check targets the relevant instance.
module tb_network_bf_in_xbar;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [7:0]  sel_a;
  logic [91:0] q;
  logic        err_clr;

  logic [91:0] od_a, od_b, od_c;
  logic        ov_a, ov_b, ov_c;
  logic        co_a, co_b, co_c;
  logic [7:0]  cc_a, cc_c;
  logic [1:0]  cc_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  network_bf_in_xbar #(.DATA_W(23), .LANES(4), .SEL_DLY(1), .OUT_REG(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sel_a(sel_a), .q(q),
    .err_clr(err_clr), .out_data(od_a), .out_valid(ov_a), .collision(co_a), .coll_cnt(cc_a)
  );

  network_bf_in_xbar #(.DATA_W(23), .LANES(4), .SEL_DLY(1), .OUT_REG(1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sel_a(sel_a), .q(q),
    .err_clr(err_clr), .out_data(od_b), .out_valid(ov_b), .collision(co_b), .coll_cnt(cc_b)
  );

  network_bf_in_xbar #(.DATA_W(23), .LANES(4), .SEL_DLY(3), .OUT_REG(0), .CNT_W(8)) dut_d3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sel_a(sel_a), .q(q),
    .err_clr(err_clr), .out_data(od_c), .out_valid(ov_c), .collision(co_c), .coll_cnt(cc_c)
  );

  function automatic logic [7:0] psel(int a0, int a1, int a2, int a3);
    return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  function automatic logic [91:0] pq(int d0, int d1, int d2, int d3);
    return {23'(d3), 23'(d2), 23'(d1), 23'(d0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_slots(input string tag, input logic [91:0] d,
                             input int s0, input int s1, input int s2, input int s3);
    logic [91:0] e;
    e = pq(s0, s1, s2, s3);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s_slot%0d", tag, j), 64'(d[j*23 +: 23]), 64'(e[j*23 +: 23]));
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; sel_a = '0; q = '0; err_clr = 1'b0;
    tick();
    tick();
    check("rst_ov", 64'(ov_a), 64'd0);
    check("rst_od", 64'(od_a != 92'd0), 64'd0);
    check("rst_coll", 64'(co_a), 64'd0);
    check("rst_cnt", 64'(cc_a), 64'd0);
    check("rst_d3_ov", 64'(ov_c), 64'd0);
    rst = 1'b1;
    tick();

    // Permutation route {2,0,3,1}.
    in_valid = 1'b1; sel_a = psel(2, 0, 3, 1);
    tick();
    check("perm_ov_early", 64'(ov_a), 64'd0);
    in_valid = 1'b0; q = pq('h11, 'h22, 'h33, 'h44);
    tick();
    check("perm_ov", 64'(ov_a), 64'd1);
    check_slots("perm", od_a, 'h22, 'h44, 'h11, 'h33);
    check("perm_coll", 64'(co_a), 64'd0);
    check("perm_cnt", 64'(cc_a), 64'd0);
    tick();
    check("perm_ov_drop", 64'(ov_a), 64'd0);

    // Collision priority {1,1,0,1}: slot1 gets bank3.
    in_valid = 1'b1; sel_a = psel(1, 1, 0, 1);
    tick();
    in_valid = 1'b0; q = pq(5, 6, 7, 8);
    tick();
    check("coll_ov", 64'(ov_a), 64'd1);
    check_slots("coll", od_a, 7, 8, 0, 0);
    check("coll_flag", 64'(co_a), 64'd1);
    check("coll_cnt", 64'(cc_a), 64'd1);
    check("coll_cnt_c2", 64'(cc_b), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_flag", 64'(co_a), 64'd0);
    check("clr_cnt_kept", 64'(cc_a), 64'd1);

    // Invalid beat with colliding selects never flags.
    in_valid = 1'b0; sel_a = psel(0, 0, 0, 0);
    tick();
    tick();
    check("inv_ov", 64'(ov_a), 64'd0);
    check("inv_coll", 64'(co_a), 64'd0);
    check("inv_cnt", 64'(cc_a), 64'd1);

    // Stall: A, B, then en=0 for three cycles, then C.
    in_valid = 1'b1; sel_a = psel(0, 1, 2, 3);
    tick();
    sel_a = psel(3, 2, 1, 0); q = pq(1, 2, 3, 4);
    tick();
    check("stall_a_ov", 64'(ov_a), 64'd1);
    check_slots("stall_a", od_a, 1, 2, 3, 4);
    en = 1'b0; sel_a = psel(1, 0, 3, 2); q = pq('hA, 'hB, 'hC, 'hD);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_hold%0d_ov", k), 64'(ov_a), 64'd1);
      check($sformatf("stall_hold%0d_s0", k), 64'(od_a[22:0]), 64'd1);
    end
    check_slots("stall_hold", od_a, 1, 2, 3, 4);
    en = 1'b1;
    tick();
    check("stall_b_ov", 64'(ov_a), 64'd1);
    check_slots("stall_b", od_a, 'hD, 'hC, 'hB, 'hA);
    in_valid = 1'b0; q = pq('h100, 'h200, 'h300, 'h400);
    tick();
    check("stall_c_ov", 64'(ov_a), 64'd1);
    check_slots("stall_c", od_a, 'h200, 'h100, 'h400, 'h300);
    tick();
    check("stall_end_ov", 64'(ov_a), 64'd0);
    check("stall_coll", 64'(co_a), 64'd0);
    check("stall_cnt", 64'(cc_a), 64'd1);
    tick();
    tick();

    // Five collided beats; err_clr held across the collided vld_d cycles.
    in_valid = 1'b1; sel_a = psel(0, 0, 0, 0); q = pq(1, 2, 3, 4);
    tick();
    err_clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("race%0d_flag", k), 64'(co_a), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("race4_flag", 64'(co_a), 64'd1);
    check_slots("sat_route", od_a, 4, 0, 0, 0);
    check("sat_cnt_c2", 64'(cc_b), 64'd3);
    check("sat_cnt_8b", 64'(cc_a), 64'd6);
    tick();
    err_clr = 1'b0;
    check("race_clr_flag", 64'(co_a), 64'd0);
    check("sat_cnt_c2_hold", 64'(cc_b), 64'd3);
    tick();
    tick();

    // Reset one cycle after in_valid drops the beat.
    in_valid = 1'b1; sel_a = psel(2, 0, 3, 1); q = pq('h11, 'h22, 'h33, 'h44);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("mid_rst_ov", 64'(ov_a), 64'd0);
    check("mid_rst_od", 64'(od_a != 92'd0), 64'd0);
    check("mid_rst_cnt", 64'(cc_a), 64'd0);
    check("mid_rst_cnt_c2", 64'(cc_b), 64'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst%0d_ov", k), 64'(ov_a), 64'd0);
      check($sformatf("post_rst%0d_d3_ov", k), 64'(ov_c), 64'd0);
    end

    // SEL_DLY=3, OUT_REG=0 permutation.
    q = '0;
    in_valid = 1'b1; sel_a = psel(2, 0, 3, 1);
    tick();
    in_valid = 1'b0; sel_a = '0;
    tick();
    check("d3_ov_early", 64'(ov_c), 64'd0);
    q = pq('h11, 'h22, 'h33, 'h44);
    tick();
    check("d3_ov", 64'(ov_c), 64'd1);
    check_slots("d3", od_c, 'h22, 'h44, 'h11, 'h33);
    check("d3_coll", 64'(co_c), 64'd0);
    tick();
    check("d3_ov_drop", 64'(ov_c), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
